// File: rtl/exp_sum_buffer_pkg.sv
// Shared softmax constants: exponent word format and exp_sum_buffer FSM encodings.
// No ports; imported by exp_sum_buffer and its storage sub-module.
package exp_sum_buffer_pkg;

  // Q4.12 exponent word produced by the pow2 stage
  localparam int unsigned DW     = 16;
  localparam int unsigned FRAC_W = 12;

  // exp_sum_buffer FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/exp_sum_buffer_mem.sv
// exp_buf_mem: N x DW word store for one softmax vector.
// Ports: clk, we/wr_addr/wr_data (synchronous write), rd_addr/rd_data (asynchronous read).
// No reset: contents are always written before they are read back.
module exp_buf_mem
  import exp_sum_buffer_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned DW  = exp_sum_buffer_pkg::DW,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [N];

  // Single write port
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Asynchronous read port
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/exp_sum_buffer.sv
// exp_sum_buffer: collects N pow2 words of a softmax vector while summing them,
// then replays the words with the finished sum to the divider.
// Ports: clk, rst (async, active-high), en (global freeze when 0),
//   in_valid/in_ready/in_pow2 (upstream word), out_valid/out_ready (downstream handshake),
//   out_pow2 (replayed word), out_sum (vector sum), out_last (Nth replayed word).
module exp_sum_buffer
  import exp_sum_buffer_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned DW  = exp_sum_buffer_pkg::DW,
  localparam int unsigned AW = $clog2(N),
  localparam int unsigned CW = $clog2(N) + 1,
  localparam int unsigned SW = DW + $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_valid,
  input  logic [DW-1:0] in_pow2,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_pow2,
  output logic [SW-1:0] out_sum,
  output logic          out_last
);

  logic [1:0]    state, state_n;
  logic [CW-1:0] wr_cnt, wr_n;
  logic [AW-1:0] rd_cnt, rd_n;
  logic [SW-1:0] sum, sum_n;
  logic          in_ready_n, out_valid_n, last_n;
  logic [DW-1:0] pow2_n;
  logic [SW-1:0] osum_n;

  logic          mem_we;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          in_fire, out_fire;
  logic [SW-1:0] sum_add;

  assign in_fire  = en & in_valid & in_ready;
  assign out_fire = en & out_valid & out_ready;
  assign sum_add  = sum + SW'(in_pow2);

  exp_buf_mem #(.N(N), .DW(DW)) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (wr_cnt[AW-1:0]),
    .wr_data (in_pow2),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      sum       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_pow2  <= '0;
      out_sum   <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      wr_cnt    <= wr_n;
      rd_cnt    <= rd_n;
      sum       <= sum_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      out_pow2  <= pow2_n;
      out_sum   <= osum_n;
      out_last  <= last_n;
    end
  end

  // Next-state and next-output logic; outputs are preloaded one cycle ahead
  // so the replayed word sits in a register while the handshake is pending.
  always_comb begin
    state_n     = state;
    wr_n        = wr_cnt;
    rd_n        = rd_cnt;
    sum_n       = sum;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    pow2_n      = out_pow2;
    osum_n      = out_sum;
    last_n      = out_last;
    mem_we      = 1'b0;
    rd_addr     = rd_cnt;

    case (state)
      ST_IDLE: begin
        // First word loads the sum rather than adding to stale contents
        if (in_fire) begin
          mem_we  = 1'b1;
          wr_n    = CW'(1);
          sum_n   = SW'(in_pow2);
          state_n = ST_FILL;
        end
      end

      ST_FILL: begin
        if (in_fire) begin
          mem_we = 1'b1;
          wr_n   = wr_cnt + CW'(1);
          sum_n  = sum_add;
          if (wr_cnt == CW'(N - 1)) begin
            // Word 0 was stored in an earlier cycle, so it can be preloaded now
            state_n     = ST_DRAIN;
            in_ready_n  = 1'b0;
            out_valid_n = 1'b1;
            pow2_n      = rd_data;
            osum_n      = sum_add;
            last_n      = 1'b0;
          end
        end
      end

      ST_DRAIN: begin
        if (out_fire) begin
          if (out_last) begin
            state_n     = ST_IDLE;
            wr_n        = '0;
            rd_n        = '0;
            sum_n       = '0;
            in_ready_n  = 1'b1;
            out_valid_n = 1'b0;
            pow2_n      = '0;
            osum_n      = '0;
            last_n      = 1'b0;
          end else begin
            rd_n    = rd_cnt + AW'(1);
            rd_addr = rd_cnt + AW'(1);
            pow2_n  = rd_data;
            last_n  = (rd_n == AW'(N - 1));
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_exp_sum_buffer.sv
// Directed testbench for exp_sum_buffer with N=4, DW=16.
module tb_exp_sum_buffer;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = DW + $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_pow2 = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_pow2;
  logic [SW-1:0] out_sum;
  logic          out_last;

  int n_checks = 0;
  int n_pass   = 0;

  exp_sum_buffer #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_pow2   (in_pow2),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pow2  (out_pow2),
    .out_sum   (out_sum),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_pow2"},  32'(out_pow2),  32'd0);
    check({tag, "_out_sum"},   32'(out_sum),   32'd0);
    check({tag, "_out_last"},  32'(out_last),  32'd0);
  endtask

  task automatic send_word(input string tag, input logic [DW-1:0] v);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_pow2  = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input string tag, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                          input logic [DW-1:0] w2, input logic [DW-1:0] w3);
    send_word(tag, w0);
    send_word(tag, w1);
    send_word(tag, w2);
    send_word(tag, w3);
  endtask

  // Drain n_words words; optionally stall before word stall_at and drive junk on the input
  task automatic drain_vec(input string tag, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                           input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                           input logic [31:0] esum, input int n_words,
                           input int stall_at, input int stall_len, input bit junk);
    logic [DW-1:0] w [4];
    int budget;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    budget = 0;
    out_ready = 1'b1;
    while (!out_valid && budget < 20) begin
      tick();
      budget++;
    end
    if (!out_valid) begin
      check({tag, "_drain_timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    if (junk) begin
      in_valid = 1'b1;
      in_pow2  = 16'hFFFF;
    end
    for (int k = 0; k < n_words; k++) begin
      if (k == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
          check({tag, "_stall_pow2"},  32'(out_pow2),  32'(w[k]));
          check({tag, "_stall_sum"},   32'(out_sum),   esum);
          check({tag, "_stall_last"},  32'(out_last),  32'(k == 3));
          tick();
        end
        out_ready = 1'b1;
      end
      check({tag, "_valid"},    32'(out_valid), 32'd1);
      check({tag, "_pow2"},     32'(out_pow2),  32'(w[k]));
      check({tag, "_sum"},      32'(out_sum),   esum);
      check({tag, "_last"},     32'(out_last),  32'(k == 3));
      check({tag, "_in_ready"}, 32'(in_ready),  32'd0);
      tick();
    end
    in_valid = 1'b0;
    if (n_words == 4) check_idle({tag, "_after"});
  endtask

  initial begin
    // Reset state
    #12;
    check_idle("reset");
    rst = 1'b0;
    #1;

    // Basic vector, sum 0x07800
    send_vec("basic", 16'h1000, 16'h2000, 16'h0800, 16'h4000);
    check("basic_latency", 32'(out_valid), 32'd1);
    drain_vec("basic", 16'h1000, 16'h2000, 16'h0800, 16'h4000, 32'h07800, 4, -1, 0, 1'b0);

    // Backpressure: 3-cycle stall before the 2nd word, sum 0x0A00
    send_vec("bp", 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    drain_vec("bp", 16'h0100, 16'h0200, 16'h0300, 16'h0400, 32'h00A00, 4, 1, 3, 1'b0);

    // en=0 freeze during FILL with a valid word presented; sum 0x00A0
    send_word("frz", 16'h0010);
    send_word("frz", 16'h0020);
    en = 1'b0;
    in_valid = 1'b1;
    in_pow2  = 16'h7777;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("frz_in_ready",  32'(in_ready),  32'd1);
      check("frz_out_valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    en = 1'b1;
    send_word("frz", 16'h0030);
    check("frz_not_full", 32'(out_valid), 32'd0);
    send_word("frz", 16'h0040);
    check("frz_full", 32'(out_valid), 32'd1);
    drain_vec("frz", 16'h0010, 16'h0020, 16'h0030, 16'h0040, 32'h000A0, 4, -1, 0, 1'b0);

    // in_valid with 0xFFFF during DRAIN is ignored; next vector sum 0x2000
    send_vec("junk", 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    drain_vec("junk", 16'h0001, 16'h0002, 16'h0003, 16'h0004, 32'h0000A, 4, -1, 0, 1'b1);
    send_vec("nojunk", 16'h0800, 16'h0800, 16'h0800, 16'h0800);
    drain_vec("nojunk", 16'h0800, 16'h0800, 16'h0800, 16'h0800, 32'h02000, 4, -1, 0, 1'b0);

    // Reset after the 2nd output word, then a fresh vector
    send_vec("rst", 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    drain_vec("rst", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 32'h00400, 2, -1, 0, 1'b0);
    rst = 1'b1;
    #2;
    check_idle("rst_async");
    rst = 1'b0;
    #1;
    check_idle("rst_release");
    send_vec("post_rst", 16'h1000, 16'h1000, 16'h1000, 16'h1000);
    drain_vec("post_rst", 16'h1000, 16'h1000, 16'h1000, 16'h1000, 32'h04000, 4, -1, 0, 1'b0);

    // Full-scale words: sum 0x3FFFC without wrap
    send_vec("max", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    drain_vec("max", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'h3FFFC, 4, 2, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
